pipe_mem_arb: RTL and testbench
===============================

# pipe_mem_arb

Single-port memory arbiter for the in-order pipeline. Shares one instruction/data memory port between the fetch stage (read-only) and the load/store unit (read/write). Keeps at most one transaction outstanding and routes each response back to its owner. Drops fetch responses made stale by a pipeline flush, so the fetch stage can redirect without waiting for memory to drain.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; write mask is DW/8 bits

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- if_req_valid_i  in  1  fetch read request
- if_req_addr_i  in  AW  fetch address (PC)
- if_req_ready_o  out  1  fetch request accepted this cycle
- if_kill_i  in  1  flush; invalidates any fetch owned or requested
- if_rsp_valid_o  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data_o  out  DW  instruction word
- ls_req_valid_i  in  1  LSU request
- ls_req_addr_i  in  AW  LSU address
- ls_req_wen_i  in  1  1 = write, 0 = read
- ls_req_wdata_i  in  DW  write data
- ls_req_wmask_i  in  DW/8  byte enables
- ls_req_ready_o  out  1  LSU request accepted this cycle
- ls_rsp_valid_o  out  1  LSU completion (1-cycle pulse; data meaningful for reads)
- ls_rsp_data_o  out  DW  load data
- mem_req_valid_o  out  1  memory request
- mem_req_addr_o / mem_req_wen_o / mem_req_wdata_o / mem_req_wmask_o  out  AW/1/DW/DW/8  latched request fields
- mem_req_ready_i  in  1  memory accepts request
- mem_rsp_valid_i  in  1  memory response
- mem_rsp_data_i  in  DW  response data
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RSP. Registers: owner (IF/LS), drop flag, latched request fields, last-grant pointer (RR build only).
- IDLE: arbitrate among valid requesters. A fetch request is ineligible while if_kill_i=1. The winner sees ready_o=1 (combinational) in the same cycle. Fields are latched and the block goes to REQ. The loser's ready_o is 0.
- Fixed priority: LSU beats fetch.
- REQ: mem_req_valid_o=1 with the latched fields, held stable until mem_req_ready_i, then go to RSP.
- RSP: on mem_rsp_valid_i, pass the data combinationally to the owner's rsp_data_o and pulse its rsp_valid_o, then go to IDLE. No new grant happens in that cycle.
- Fetch requests always drive wen=0 and wmask=0.
- Kill: if_kill_i=1 while owner=IF in REQ or RSP sets drop. The memory transaction still completes, if_rsp_valid_o stays 0, and the block returns to IDLE. Kill while owner=LS has no effect.
- Kill in the same cycle as the IF response suppresses that response.
- drop clears on entry to IDLE.
- mem_rsp_valid_i in IDLE or REQ is a protocol error and is ignored.
- rsp_data_o of the non-owner is don't-care; drive it with mem_rsp_data_i.

## Timing
- Reset values: state IDLE, owner IF, drop 0, latched fields 0, pointer = IF. While in reset, every valid/ready output is 0. After reset release, ready_o is combinational from requests in IDLE.
- Minimum transaction: accept at cycle 0, mem_req_valid_o at cycle 1, memory handshake at cycle 1, response at cycle ≥2, back in IDLE at cycle ≥3. Back-to-back grants are therefore spaced ≥3 cycles apart.
- Memory must not respond in the same cycle as its own request handshake.
- rst_i asserted mid-transaction abandons it. No response is issued, and the memory side must be reset together with this block.
- Request fields are sampled only in the accept cycle. Requester inputs are don't-care afterward.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid, grant the one not granted last. The pointer updates on each grant and resets to IF, so the first contended grant goes to LSU.
- Not defined: fixed LSU-over-fetch priority, and no pointer register.

## Test plan
- Single fetch: if_req addr 0x80000000; memory ready at once, rsp 0x00000413 one cycle later -> if_req_ready_o at cycle 0, mem_req_valid_o at cycle 1 with addr 0x80000000 and wen 0, if_rsp_valid_o pulse with 0x00000413 at cycle 2.
- Contention: fetch 0x80000004 and LSU read 0x80001000 both valid in the same cycle -> LSU granted first. The fetch is granted at the next IDLE and is stalled until then (non-RR build).
- Write: LSU wen=1, addr 0x80002000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready_i held low 3 cycles -> fields stable for all 4 cycles of mem_req_valid_o; ls_rsp_valid_o pulses once.
- Kill in flight: fetch 0x80000008 accepted, if_kill_i in RSP before the response -> no if_rsp_valid_o; busy_o drops after the memory response. A new fetch 0x80000100 is accepted in the following IDLE.
- Kill in IDLE: if_kill_i=1 with if_req_valid_i=1 -> if_req_ready_o=0 and no memory request is issued.
- RR build: both requesters held valid for 4 transactions -> grants go LS, IF, LS, IF.

Source files
------------

// File: rtl/pipe_mem_arb.sv
// Single-port memory arbiter sharing one memory port between fetch and LSU; one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed LSU-over-fetch priority.
module pipe_mem_arb #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_valid_i,
    input  logic [AW-1:0]   if_req_addr_i,
    output logic            if_req_ready_o,
    input  logic            if_kill_i,
    output logic            if_rsp_valid_o,
    output logic [DW-1:0]   if_rsp_data_o,
    input  logic            ls_req_valid_i,
    input  logic [AW-1:0]   ls_req_addr_i,
    input  logic            ls_req_wen_i,
    input  logic [DW-1:0]   ls_req_wdata_i,
    input  logic [DW/8-1:0] ls_req_wmask_i,
    output logic            ls_req_ready_o,
    output logic            ls_rsp_valid_o,
    output logic [DW-1:0]   ls_rsp_data_o,
    output logic            mem_req_valid_o,
    output logic [AW-1:0]   mem_req_addr_o,
    output logic            mem_req_wen_o,
    output logic [DW-1:0]   mem_req_wdata_o,
    output logic [DW/8-1:0] mem_req_wmask_o,
    input  logic            mem_req_ready_i,
    input  logic            mem_rsp_valid_i,
    input  logic [DW-1:0]   mem_rsp_data_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q;
    logic               drop_q;
    logic [AW-1:0]      addr_q;
    logic               wen_q;
    logic [DW-1:0]      wdata_q;
    logic [DW/8-1:0]    wmask_q;
    logic               grant_if, grant_ls;
    logic               if_elig;

`ifdef MEM_ARB_RR_EN
    owner_t             last_q;
`endif

    assign if_elig = if_req_valid_i && !if_kill_i;

    // Grants are gated by rst_i so ready stays low while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == S_IDLE && !rst_i) begin
`ifdef MEM_ARB_RR_EN
            if (ls_req_valid_i && if_elig) begin
                if (last_q == OWN_LS) grant_if = 1'b1;
                else                  grant_ls = 1'b1;
            end else begin
                grant_ls = ls_req_valid_i;
                grant_if = if_elig;
            end
`else
            grant_ls = ls_req_valid_i;
            grant_if = if_elig && !ls_req_valid_i;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_if || grant_ls) state_d = S_REQ;
            S_REQ:   if (mem_req_ready_i)      state_d = S_RSP;
            S_RSP:   if (mem_rsp_valid_i)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant_ls) begin
            owner_q <= OWN_LS;
            addr_q  <= ls_req_addr_i;
            wen_q   <= ls_req_wen_i;
            wdata_q <= ls_req_wdata_i;
            wmask_q <= ls_req_wmask_i;
        end else if (grant_if) begin
            owner_q <= OWN_IF;
            addr_q  <= if_req_addr_i;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end
    end

    // A kill only marks the fetch as stale; the memory transaction still runs to completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            drop_q <= 1'b0;
        else if (state_d == S_IDLE)
            drop_q <= 1'b0;
        else if (if_kill_i && owner_q == OWN_IF && state_q != S_IDLE)
            drop_q <= 1'b1;
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         last_q <= OWN_IF;
        else if (grant_ls) last_q <= OWN_LS;
        else if (grant_if) last_q <= OWN_IF;
    end
`endif

    always_comb begin
        if_req_ready_o  = grant_if;
        ls_req_ready_o  = grant_ls;
        mem_req_valid_o = (state_q == S_REQ);
        mem_req_addr_o  = addr_q;
        mem_req_wen_o   = wen_q;
        mem_req_wdata_o = wdata_q;
        mem_req_wmask_o = wmask_q;
        if_rsp_valid_o  = (state_q == S_RSP) && mem_rsp_valid_i && (owner_q == OWN_IF)
                          && !drop_q && !if_kill_i;
        ls_rsp_valid_o  = (state_q == S_RSP) && mem_rsp_valid_i && (owner_q == OWN_LS);
        if_rsp_data_o   = mem_rsp_data_i;
        ls_rsp_data_o   = mem_rsp_data_i;
        busy_o          = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Directed self-checking bench for pipe_mem_arb; memory side is driven as explicit per-cycle vectors.
module tb_pipe_mem_arb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_valid_i = 1'b0;
    logic [31:0] if_req_addr_i = '0;
    logic        if_req_ready_o;
    logic        if_kill_i = 1'b0;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        ls_req_valid_i = 1'b0;
    logic [31:0] ls_req_addr_i = '0;
    logic        ls_req_wen_i = 1'b0;
    logic [31:0] ls_req_wdata_i = '0;
    logic [3:0]  ls_req_wmask_i = '0;
    logic        ls_req_ready_o;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rsp_data_o;
    logic        mem_req_valid_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_wen_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wmask_o;
    logic        mem_req_ready_i = 1'b0;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_data_i = '0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    pipe_mem_arb #(.AW(32), .DW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i),
        .if_req_ready_o(if_req_ready_o), .if_kill_i(if_kill_i),
        .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
        .ls_req_valid_i(ls_req_valid_i), .ls_req_addr_i(ls_req_addr_i),
        .ls_req_wen_i(ls_req_wen_i), .ls_req_wdata_i(ls_req_wdata_i),
        .ls_req_wmask_i(ls_req_wmask_i), .ls_req_ready_o(ls_req_ready_o),
        .ls_rsp_valid_o(ls_rsp_valid_o), .ls_rsp_data_o(ls_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wen_o(mem_req_wen_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_wmask_o(mem_req_wmask_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic exp_ls [4];

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_ls[0] = 1'b1; exp_ls[1] = 1'b0; exp_ls[2] = 1'b1; exp_ls[3] = 1'b0;
`else
        exp_ls[0] = 1'b1; exp_ls[1] = 1'b1; exp_ls[2] = 1'b1; exp_ls[3] = 1'b1;
`endif
        // Reset: requests present but every valid/ready must stay low.
        if_req_valid_i = 1'b1;
        ls_req_valid_i = 1'b1;
        tick();
        settle();
        chk1("rst_if_ready", if_req_ready_o, 1'b0);
        chk1("rst_ls_ready", ls_req_ready_o, 1'b0);
        chk1("rst_mem_valid", mem_req_valid_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk32("rst_addr", mem_req_addr_o, 32'h0);
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;

        // Single fetch.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0000;
        settle();
        chk1("f1_if_ready", if_req_ready_o, 1'b1);
        chk1("f1_ls_ready", ls_req_ready_o, 1'b0);
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        chk1("f1_mem_valid", mem_req_valid_o, 1'b1);
        chk32("f1_mem_addr", mem_req_addr_o, 32'h8000_0000);
        chk1("f1_mem_wen", mem_req_wen_o, 1'b0);
        chk32("f1_mem_wmask", {28'h0, mem_req_wmask_o}, 32'h0);
        chk1("f1_busy", busy_o, 1'b1);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0413;
        settle();
        chk1("f1_if_rsp_valid", if_rsp_valid_o, 1'b1);
        chk32("f1_if_rsp_data", if_rsp_data_o, 32'h0000_0413);
        chk1("f1_ls_rsp_valid", ls_rsp_valid_o, 1'b0);
        tick();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk1("f1_idle_busy", busy_o, 1'b0);
        chk1("f1_rsp_gone", if_rsp_valid_o, 1'b0);

        // Contention: LSU wins, fetch stalls until the next IDLE.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0004;
        ls_req_valid_i = 1'b1;
        ls_req_addr_i  = 32'h8000_1000;
        ls_req_wen_i   = 1'b0;
        settle();
        chk1("c_ls_ready", ls_req_ready_o, 1'b1);
        chk1("c_if_ready", if_req_ready_o, 1'b0);
        tick();
        ls_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        chk32("c_ls_addr", mem_req_addr_o, 32'h8000_1000);
        chk1("c_if_stall_req", if_req_ready_o, 1'b0);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h1111_2222;
        settle();
        chk1("c_ls_rsp_valid", ls_rsp_valid_o, 1'b1);
        chk32("c_ls_rsp_data", ls_rsp_data_o, 32'h1111_2222);
        chk1("c_if_rsp_quiet", if_rsp_valid_o, 1'b0);
        chk1("c_if_stall_rsp", if_req_ready_o, 1'b0);
        tick();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk1("c_if_ready_late", if_req_ready_o, 1'b1);
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        chk32("c_if_addr", mem_req_addr_o, 32'h8000_0004);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0010_0093;
        settle();
        chk1("c_if_rsp_valid", if_rsp_valid_o, 1'b1);
        chk32("c_if_rsp_data", if_rsp_data_o, 32'h0010_0093);
        tick();
        mem_rsp_valid_i = 1'b0;

        // Write with memory stalling three cycles; fields must hold while requester inputs change.
        ls_req_valid_i = 1'b1;
        ls_req_addr_i  = 32'h8000_2000;
        ls_req_wen_i   = 1'b1;
        ls_req_wdata_i = 32'hDEAD_BEEF;
        ls_req_wmask_i = 4'hF;
        settle();
        chk1("w_ls_ready", ls_req_ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            ls_req_valid_i  = 1'b0;
            ls_req_addr_i   = 32'h1234_5678;
            ls_req_wen_i    = 1'b0;
            ls_req_wdata_i  = 32'h0BAD_F00D;
            ls_req_wmask_i  = 4'h3;
            mem_req_ready_i = (i == 3);
            settle();
            chk1($sformatf("w_mem_valid_%0d", i), mem_req_valid_o, 1'b1);
            chk32($sformatf("w_addr_%0d", i), mem_req_addr_o, 32'h8000_2000);
            chk32($sformatf("w_wdata_%0d", i), mem_req_wdata_o, 32'hDEAD_BEEF);
            chk1($sformatf("w_wen_%0d", i), mem_req_wen_o, 1'b1);
            chk32($sformatf("w_wmask_%0d", i), {28'h0, mem_req_wmask_o}, 32'hF);
        end
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0;
        settle();
        chk1("w_mem_valid_off", mem_req_valid_o, 1'b0);
        chk1("w_ls_rsp_valid", ls_rsp_valid_o, 1'b1);
        tick();
        mem_rsp_valid_i = 1'b0;
        settle();
        chk1("w_ls_rsp_once", ls_rsp_valid_o, 1'b0);
        chk1("w_idle", busy_o, 1'b0);

        // Kill while waiting for the response.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0008;
        settle();
        chk1("k_if_ready", if_req_ready_o, 1'b1);
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        tick();
        mem_req_ready_i = 1'b0;
        if_kill_i       = 1'b1;
        settle();
        chk1("k_busy_rsp", busy_o, 1'b1);
        tick();
        if_kill_i       = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hCAFE_0001;
        settle();
        chk1("k_rsp_dropped", if_rsp_valid_o, 1'b0);
        chk1("k_busy_last", busy_o, 1'b1);
        tick();
        mem_rsp_valid_i = 1'b0;
        if_req_valid_i  = 1'b1;
        if_req_addr_i   = 32'h8000_0100;
        settle();
        chk1("k_idle", busy_o, 1'b0);
        chk1("k_new_ready", if_req_ready_o, 1'b1);
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        settle();
        chk32("k_new_addr", mem_req_addr_o, 32'h8000_0100);
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'h0000_0013;
        settle();
        chk1("k_new_rsp", if_rsp_valid_o, 1'b1);
        tick();
        mem_rsp_valid_i = 1'b0;

        // Kill coincident with the fetch response.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0200;
        settle();
        tick();
        if_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        if_kill_i       = 1'b1;
        settle();
        chk1("ks_rsp_suppressed", if_rsp_valid_o, 1'b0);
        tick();
        mem_rsp_valid_i = 1'b0;
        if_kill_i       = 1'b0;
        settle();
        chk1("ks_idle", busy_o, 1'b0);

        // Kill in IDLE blocks the fetch request.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0300;
        if_kill_i      = 1'b1;
        settle();
        chk1("ki_if_ready", if_req_ready_o, 1'b0);
        tick();
        settle();
        chk1("ki_no_mem_req", mem_req_valid_o, 1'b0);
        chk1("ki_busy", busy_o, 1'b0);
        if_req_valid_i = 1'b0;
        if_kill_i      = 1'b0;

        // Both requesters held valid for four transactions.
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h8000_0400;
        ls_req_valid_i = 1'b1;
        ls_req_addr_i  = 32'h8000_3000;
        ls_req_wen_i   = 1'b0;
        for (int t = 0; t < 4; t++) begin
            settle();
            chk1($sformatf("rr_ls_ready_%0d", t), ls_req_ready_o, exp_ls[t]);
            chk1($sformatf("rr_if_ready_%0d", t), if_req_ready_o, !exp_ls[t]);
            tick();
            mem_req_ready_i = 1'b1;
            settle();
            chk32($sformatf("rr_addr_%0d", t), mem_req_addr_o,
                  exp_ls[t] ? 32'h8000_3000 : 32'h8000_0400);
            tick();
            mem_req_ready_i = 1'b0;
            mem_rsp_valid_i = 1'b1;
            settle();
            chk1($sformatf("rr_ls_rsp_%0d", t), ls_rsp_valid_o, exp_ls[t]);
            chk1($sformatf("rr_if_rsp_%0d", t), if_rsp_valid_o, !exp_ls[t]);
            tick();
            mem_rsp_valid_i = 1'b0;
        end
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        settle();
        chk1("end_idle", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
